mem_stage_ctrl: RTL and testbench

- Memory-stage controller between the X/M pipeline latch and data memory / memory-mapped peripherals (feeder servo, scale, timers).
- Decodes the X/M instruction and issues single-cycle stores to data memory.
- Sequences multi-cycle loads and all MMIO accesses, holding the pipeline with `stall` until each access completes.
- Delivers load data to the M/W latch.

---
 rtl/mem_stage_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between the X/M latch and data
// memory / memory-mapped peripherals.
//   - Plain data-memory stores complete in the IDLE cycle with no stall.
//   - Data-memory loads stall for DMEM_LAT+1 cycles.
//   - Every MMIO access stalls until io_ack arrives or IO_TIMEOUT expires.
//   - After any stalled access, one DONE cycle releases stall so the
//     X/M latch can advance.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   xm_valid/insn/addr/data      X/M latch contents
//   mem_addr/wdata/we, mem_rdata data-memory port (addr/wdata/we combinational)
//   io_addr/wdata/we/req         peripheral request (registered)
//   io_ack, io_rdata             peripheral completion and read data
//   stall                        pipeline freeze (combinational)
//   load_data                    result of the last completed load
//   bus_err                      sticky MMIO timeout flag
module mem_stage_ctrl #(
    parameter int unsigned DMEM_LAT   = 1,
    parameter int unsigned ADDR_W     = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
    parameter int unsigned IO_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              xm_valid,
    input  logic [31:0]       xm_insn,
    input  logic [31:0]       xm_addr,
    input  logic [31:0]       xm_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    output logic              io_we,
    output logic              io_req,
    input  logic              io_ack,
    input  logic [31:0]       io_rdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              bus_err
);

    localparam logic [4:0]  OP_SW  = 5'b00111;
    localparam logic [4:0]  OP_LW  = 5'b01000;
    localparam int unsigned LCNT_W = (DMEM_LAT > 1) ? $clog2(DMEM_LAT) : 1;
    localparam int unsigned TCNT_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DMEM_WAIT = 2'd1,
        IO_WAIT   = 2'd2,
        DONE      = 2'd3
    } stateT;

    stateT             state;
    logic [LCNT_W-1:0] loadCnt;
    logic [TCNT_W-1:0] ioCnt;

    logic isSw;
    logic isLw;
    logic isMmio;
    logic access;

    // Only the opcode field of the instruction matters here.
    logic unusedInsn;
    assign unusedInsn = |xm_insn[26:0];

    // Instruction decode.
    assign isSw   = (xm_insn[31:27] == OP_SW);
    assign isLw   = (xm_insn[31:27] == OP_LW);
    assign isMmio = (xm_addr >= MMIO_BASE);
    assign access = xm_valid & (isSw | isLw);

    // Data-memory address/data follow the X/M latch directly.
    assign mem_addr  = xm_addr[ADDR_W-1:0];
    assign mem_wdata = xm_data;

    // Stall and store enable come straight from state plus the IDLE decode.
    always_comb begin
        stall  = 1'b0;
        mem_we = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (isMmio || isLw) begin
                        stall = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            DMEM_WAIT: stall = 1'b1;
            IO_WAIT:   stall = 1'b1;
            default:   stall = 1'b0;
        endcase
    end

    // Access sequencer with registered peripheral interface and results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            loadCnt   <= '0;
            ioCnt     <= '0;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
            load_data <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && isMmio) begin
                        io_req   <= 1'b1;
                        io_we    <= isSw;
                        io_addr  <= xm_addr;
                        io_wdata <= xm_data;
                        ioCnt    <= '0;
                        state    <= IO_WAIT;
                    end else if (access && isLw) begin
                        loadCnt <= LCNT_W'(DMEM_LAT - 1);
                        state   <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (loadCnt == '0) begin
                        load_data <= mem_rdata;
                        state     <= DONE;
                    end else begin
                        loadCnt <= loadCnt - LCNT_W'(1);
                    end
                end
                IO_WAIT: begin
                    // An ack on the final timeout cycle still wins over the error.
                    if (io_ack) begin
                        io_req <= 1'b0;
                        io_we  <= 1'b0;
                        if (!io_we) begin
                            load_data <= io_rdata;
                        end
                        state <= DONE;
                    end else if (ioCnt == TCNT_W'(IO_TIMEOUT - 1)) begin
                        io_req  <= 1'b0;
                        io_we   <= 1'b0;
                        bus_err <= 1'b1;
                        if (!io_we) begin
                            load_data <= '0;
                        end
                        state <= DONE;
                    end else begin
                        ioCnt <= ioCnt + TCNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed scenarios plus a randomized
// transaction stream checked against a transaction-level reference model.
module tb_mem_stage_ctrl;

    localparam int unsigned DMEM_LAT   = 1;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned IO_TIMEOUT = 16;
    localparam logic [4:0]  OP_SW      = 5'b00111;
    localparam logic [4:0]  OP_LW      = 5'b01000;

    logic              clock;
    logic              reset;
    logic              xm_valid;
    logic [31:0]       xm_insn;
    logic [31:0]       xm_addr;
    logic [31:0]       xm_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic [31:0]       io_addr;
    logic [31:0]       io_wdata;
    logic              io_we;
    logic              io_req;
    logic              io_ack;
    logic [31:0]       io_rdata;
    logic              stall;
    logic [31:0]       load_data;
    logic              bus_err;

    int passCount;
    int checkCount;

    // Data memory environment (registered read) and the reference copy.
    logic [31:0] dmem   [0:4095];
    logic [31:0] refMem [0:4095];
    logic [31:0] refLoad;
    logic        refBusErr;

    // Observations of the most recent transaction.
    int          obsStall;
    int          obsWe;
    int          obsReq;
    logic [31:0] obsMemAddr;
    logic [31:0] obsIoAddr;
    logic [31:0] obsIoWdata;
    logic        obsIoWe;
    logic        obsHeld;
    logic [31:0] obsLoad;

    mem_stage_ctrl #(
        .DMEM_LAT   (DMEM_LAT),
        .ADDR_W     (ADDR_W),
        .MMIO_BASE  (32'h0000_F000),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .xm_valid  (xm_valid),
        .xm_insn   (xm_insn),
        .xm_addr   (xm_addr),
        .xm_data   (xm_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_we     (io_we),
        .io_req    (io_req),
        .io_ack    (io_ack),
        .io_rdata  (io_rdata),
        .stall     (stall),
        .load_data (load_data),
        .bus_err   (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] seed_word(input int i);
        return 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= seed_word(i);
        end else if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= dmem[mem_addr];
    end

    task automatic init_ref_mem();
        for (int i = 0; i < 4096; i++) refMem[i] = seed_word(i);
    endtask

    // Present one instruction at a negedge and hold it until stall drops;
    // the peripheral acks after ackDelay cycles of io_req (never if < 0).
    task automatic drive_insn(input logic v, input logic [4:0] op, input logic [31:0] addr,
                              input logic [31:0] data, input int ackDelay, input logic [31:0] ioRd);
        bit finished;
        finished = 1'b0;
        obsStall = 0; obsWe = 0; obsReq = 0; obsHeld = 1'b1;
        obsMemAddr = '0; obsIoAddr = '0; obsIoWdata = '0; obsIoWe = 1'b0; obsLoad = '0;
        xm_valid = v;
        xm_insn  = {op, 27'($urandom)};
        xm_addr  = addr;
        xm_data  = data;
        for (int c = 0; c < 100 && !finished; c++) begin
            if (io_req) io_ack = (obsReq == ackDelay);
            else        io_ack = ($urandom_range(0, 3) == 0);
            io_rdata = (io_ack && io_req) ? ioRd : $urandom;
            #1;
            if (c == 0) obsMemAddr = 32'(mem_addr);
            if (mem_we) obsWe++;
            if (io_req) begin
                if (obsReq == 0) begin
                    obsIoAddr = io_addr; obsIoWdata = io_wdata; obsIoWe = io_we;
                end else if (io_addr !== obsIoAddr || io_wdata !== obsIoWdata || io_we !== obsIoWe) begin
                    obsHeld = 1'b0;
                end
                obsReq++;
            end
            if (stall) obsStall++;
            else begin
                finished = 1'b1;
                obsLoad  = load_data;
            end
            @(negedge clock);
        end
        xm_valid = 1'b0;
        io_ack   = 1'b0;
        xm_insn  = {5'b11111, 27'($urandom)};
    endtask

    task automatic test_reset();
        reset = 1'b1; xm_valid = 1'b0; io_ack = 1'b0; io_rdata = '0;
        xm_insn = '0; xm_addr = '0; xm_data = '0;
        repeat (3) @(negedge clock);
        #1;
        checkCount++; if (io_req !== 1'b0) $display("FAIL reset_io_req: got %b want 0", io_req); else passCount++;
        checkCount++; if (io_we !== 1'b0) $display("FAIL reset_io_we: got %b want 0", io_we); else passCount++;
        checkCount++; if (io_addr !== 32'h0) $display("FAIL reset_io_addr: got %h want 0", io_addr); else passCount++;
        checkCount++; if (io_wdata !== 32'h0) $display("FAIL reset_io_wdata: got %h want 0", io_wdata); else passCount++;
        checkCount++; if (load_data !== 32'h0) $display("FAIL reset_load_data: got %h want 0", load_data); else passCount++;
        checkCount++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else passCount++;
        checkCount++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passCount++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_dmem_store();
        drive_insn(1'b1, OP_SW, 32'h10, 32'hDEAD_BEEF, -1, '0);
        refMem[12'h010] = 32'hDEAD_BEEF;
        checkCount++; if (obsWe !== 1) $display("FAIL sw_mem_we_cycles: got %0d want 1", obsWe); else passCount++;
        checkCount++; if (obsStall !== 0) $display("FAIL sw_stall: got %0d want 0", obsStall); else passCount++;
        checkCount++; if (obsMemAddr !== 32'h10) $display("FAIL sw_mem_addr: got %h want 010", obsMemAddr); else passCount++;
        checkCount++; if (dmem[12'h010] !== 32'hDEAD_BEEF) $display("FAIL sw_dmem: got %h want deadbeef", dmem[12'h010]); else passCount++;
        #1;
        checkCount++; if (mem_we !== 1'b0) $display("FAIL sw_idle_mem_we: got %b want 0", mem_we); else passCount++;
        @(negedge clock);
    endtask

    task automatic test_dmem_load();
        drive_insn(1'b1, OP_SW, 32'h20, 32'h1234_5678, -1, '0);
        drive_insn(1'b1, OP_LW, 32'h20, 32'h0, -1, '0);
        checkCount++; if (obsStall !== int'(DMEM_LAT + 1)) $display("FAIL lw_stall: got %0d want %0d", obsStall, DMEM_LAT + 1); else passCount++;
        checkCount++; if (obsLoad !== 32'h1234_5678) $display("FAIL lw_done_data: got %h want 12345678", obsLoad); else passCount++;
        // Back-to-back load pays the full latency again.
        drive_insn(1'b1, OP_LW, 32'h10, 32'h0, -1, '0);
        checkCount++; if (obsStall !== int'(DMEM_LAT + 1)) $display("FAIL b2b_lw_stall: got %0d want %0d", obsStall, DMEM_LAT + 1); else passCount++;
        checkCount++; if (obsLoad !== 32'hDEAD_BEEF) $display("FAIL b2b_lw_data: got %h want deadbeef", obsLoad); else passCount++;
        drive_insn(1'b1, OP_SW, 32'h30, 32'h0BAD_F00D, -1, '0);
        refMem[12'h030] = 32'h0BAD_F00D;
        checkCount++; if (obsStall !== 0) $display("FAIL after_lw_sw_stall: got %0d want 0", obsStall); else passCount++;
        checkCount++; if (obsWe !== 1) $display("FAIL after_lw_sw_we: got %0d want 1", obsWe); else passCount++;
    endtask

    task automatic test_mmio_store();
        drive_insn(1'b1, OP_SW, 32'hF004, 32'h5A, 3, '0);
        checkCount++; if (obsWe !== 0) $display("FAIL mmio_sw_mem_we: got %0d want 0", obsWe); else passCount++;
        checkCount++; if (obsReq !== 4) $display("FAIL mmio_sw_req_cycles: got %0d want 4", obsReq); else passCount++;
        checkCount++; if (obsStall !== 5) $display("FAIL mmio_sw_stall: got %0d want 5", obsStall); else passCount++;
        checkCount++; if (obsIoAddr !== 32'hF004) $display("FAIL mmio_sw_io_addr: got %h want f004", obsIoAddr); else passCount++;
        checkCount++; if (obsIoWdata !== 32'h5A) $display("FAIL mmio_sw_io_wdata: got %h want 5a", obsIoWdata); else passCount++;
        checkCount++; if (obsIoWe !== 1'b1) $display("FAIL mmio_sw_io_we: got %b want 1", obsIoWe); else passCount++;
        checkCount++; if (obsHeld !== 1'b1) $display("FAIL mmio_sw_held: got %b want 1", obsHeld); else passCount++;
        checkCount++; if (load_data !== 32'hDEAD_BEEF) $display("FAIL mmio_sw_load_kept: got %h want deadbeef", load_data); else passCount++;
        checkCount++; if (io_req !== 1'b0) $display("FAIL mmio_sw_req_dropped: got %b want 0", io_req); else passCount++;
    endtask

    task automatic test_mmio_load();
        drive_insn(1'b1, OP_LW, 32'hF008, 32'h0, 0, 32'hCAFE);
        checkCount++; if (obsLoad !== 32'hCAFE) $display("FAIL mmio_lw_data: got %h want cafe", obsLoad); else passCount++;
        checkCount++; if (bus_err !== 1'b0) $display("FAIL mmio_lw_bus_err: got %b want 0", bus_err); else passCount++;
        checkCount++; if (obsStall !== 2) $display("FAIL mmio_lw_stall: got %0d want 2", obsStall); else passCount++;
        checkCount++; if (obsIoWe !== 1'b0) $display("FAIL mmio_lw_io_we: got %b want 0", obsIoWe); else passCount++;
        // Ack on the last allowed cycle counts as success.
        drive_insn(1'b1, OP_LW, 32'hF010, 32'h0, int'(IO_TIMEOUT) - 1, 32'hBEEF_0001);
        checkCount++; if (obsLoad !== 32'hBEEF_0001) $display("FAIL edge_ack_data: got %h want beef0001", obsLoad); else passCount++;
        checkCount++; if (bus_err !== 1'b0) $display("FAIL edge_ack_bus_err: got %b want 0", bus_err); else passCount++;
        checkCount++; if (obsReq !== int'(IO_TIMEOUT)) $display("FAIL edge_ack_req: got %0d want %0d", obsReq, IO_TIMEOUT); else passCount++;
        drive_insn(1'b1, OP_LW, 32'hF008, 32'h0, 1, 32'hCAFE);
    endtask

    task automatic test_timeout();
        drive_insn(1'b1, OP_LW, 32'hF00C, 32'h0, -1, '0);
        checkCount++; if (obsReq !== int'(IO_TIMEOUT)) $display("FAIL timeout_req: got %0d want %0d", obsReq, IO_TIMEOUT); else passCount++;
        checkCount++; if (obsStall !== int'(IO_TIMEOUT) + 1) $display("FAIL timeout_stall: got %0d want %0d", obsStall, IO_TIMEOUT + 1); else passCount++;
        checkCount++; if (bus_err !== 1'b1) $display("FAIL timeout_bus_err: got %b want 1", bus_err); else passCount++;
        checkCount++; if (obsLoad !== 32'h0) $display("FAIL timeout_load: got %h want 0", obsLoad); else passCount++;
        checkCount++; if (io_req !== 1'b0) $display("FAIL timeout_req_drop: got %b want 0", io_req); else passCount++;
        drive_insn(1'b1, OP_SW, 32'h40, 32'h7777_1111, -1, '0);
        refMem[12'h040] = 32'h7777_1111;
        drive_insn(1'b1, OP_LW, 32'h40, 32'h0, -1, '0);
        checkCount++; if (bus_err !== 1'b1) $display("FAIL bus_err_sticky: got %b want 1", bus_err); else passCount++;
        checkCount++; if (obsLoad !== 32'h7777_1111) $display("FAIL post_err_lw: got %h want 77771111", obsLoad); else passCount++;
    endtask

    task automatic test_reset_mid_wait();
        xm_valid = 1'b1; xm_insn = {OP_LW, 27'd0}; xm_addr = 32'hF00C; xm_data = '0; io_ack = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        checkCount++; if (io_req !== 1'b1) $display("FAIL midwait_req_pre: got %b want 1", io_req); else passCount++;
        #1;
        reset = 1'b1; xm_valid = 1'b0;
        #1;
        checkCount++; if (io_req !== 1'b0) $display("FAIL midwait_req: got %b want 0", io_req); else passCount++;
        checkCount++; if (stall !== 1'b0) $display("FAIL midwait_stall: got %b want 0", stall); else passCount++;
        checkCount++; if (load_data !== 32'h0) $display("FAIL midwait_load: got %h want 0", load_data); else passCount++;
        checkCount++; if (bus_err !== 1'b0) $display("FAIL midwait_bus_err: got %b want 0", bus_err); else passCount++;
        checkCount++; if (io_addr !== 32'h0) $display("FAIL midwait_io_addr: got %h want 0", io_addr); else passCount++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        init_ref_mem();
        @(negedge clock);
        io_ack = 1'b1; io_rdata = 32'h1111_2222;
        @(negedge clock);
        io_ack = 1'b0;
        #1;
        checkCount++; if (io_req !== 1'b0) $display("FAIL late_ack_req: got %b want 0", io_req); else passCount++;
        checkCount++; if (stall !== 1'b0) $display("FAIL late_ack_stall: got %b want 0", stall); else passCount++;
        checkCount++; if (load_data !== 32'h0) $display("FAIL late_ack_load: got %h want 0", load_data); else passCount++;
        @(negedge clock);
        refLoad = '0; refBusErr = 1'b0;
    endtask

    task automatic test_random();
        int          kind;
        int          ack;
        int          expStall;
        int          expReq;
        int          expWe;
        int          ioCycles;
        logic        v;
        logic        isMmio;
        logic        isAccess;
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ioRd;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            v = 1'b1; data = $urandom; ioRd = $urandom; ack = -1;
            addr = 32'($urandom_range(0, 15)) | (32'($urandom_range(0, 13)) << 12);
            if ($urandom_range(0, 9) == 0) addr = 32'h0000_EFFF;
            op = OP_SW;
            case (kind)
                0, 1, 2: op = OP_SW;
                3, 4, 5: op = OP_LW;
                6, 7: begin
                    op   = (kind == 6) ? OP_SW : OP_LW;
                    addr = 32'hF000 + 32'($urandom_range(0, 255));
                    if ($urandom_range(0, 7) == 0) addr = 32'hF000;
                    if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF0;
                    ack = $urandom_range(0, 6);
                    if ($urandom_range(0, 7) == 0) ack = int'(IO_TIMEOUT) - 1;
                    if ($urandom_range(0, 7) == 0) ack = int'(IO_TIMEOUT) + 4;
                end
                8: begin
                    op = 5'($urandom_range(9, 31));
                    if ($urandom_range(0, 1) == 0) op = 5'($urandom_range(0, 6));
                end
                default: begin
                    v  = 1'b0;
                    op = ($urandom_range(0, 1) == 0) ? OP_SW : OP_LW;
                end
            endcase
            // Reference model: effects of one instruction at transaction level.
            isAccess = v && (op == OP_SW || op == OP_LW);
            isMmio   = (addr >= 32'hF000);
            expStall = 0; expReq = 0; expWe = 0;
            if (isAccess && isMmio) begin
                ioCycles = (ack >= 0 && ack < int'(IO_TIMEOUT)) ? ack + 1 : int'(IO_TIMEOUT);
                expStall = 1 + ioCycles;
                expReq   = ioCycles;
                if (ack < 0 || ack >= int'(IO_TIMEOUT)) begin
                    refBusErr = 1'b1;
                    if (op == OP_LW) refLoad = '0;
                end else if (op == OP_LW) begin
                    refLoad = ioRd;
                end
            end else if (isAccess && op == OP_SW) begin
                expWe = 1;
                refMem[addr[11:0]] = data;
            end else if (isAccess) begin
                expStall = int'(DMEM_LAT) + 1;
                refLoad  = refMem[addr[11:0]];
            end
            drive_insn(v, op, addr, data, ack, ioRd);
            checkCount++; if (obsStall !== expStall) $display("FAIL rnd%0d_stall: got %0d want %0d", n, obsStall, expStall); else passCount++;
            checkCount++; if (obsWe !== expWe) $display("FAIL rnd%0d_mem_we: got %0d want %0d", n, obsWe, expWe); else passCount++;
            checkCount++; if (obsReq !== expReq) $display("FAIL rnd%0d_io_req: got %0d want %0d", n, obsReq, expReq); else passCount++;
            checkCount++; if (load_data !== refLoad) $display("FAIL rnd%0d_load: got %h want %h", n, load_data, refLoad); else passCount++;
            checkCount++; if (bus_err !== refBusErr) $display("FAIL rnd%0d_bus_err: got %b want %b", n, bus_err, refBusErr); else passCount++;
            checkCount++; if (dmem[addr[11:0]] !== refMem[addr[11:0]]) $display("FAIL rnd%0d_dmem: got %h want %h", n, dmem[addr[11:0]], refMem[addr[11:0]]); else passCount++;
            if (isAccess && isMmio) begin
                checkCount++; if (obsIoAddr !== addr) $display("FAIL rnd%0d_io_addr: got %h want %h", n, obsIoAddr, addr); else passCount++;
                checkCount++; if (obsIoWdata !== data) $display("FAIL rnd%0d_io_wdata: got %h want %h", n, obsIoWdata, data); else passCount++;
                checkCount++; if (obsIoWe !== (op == OP_SW)) $display("FAIL rnd%0d_io_we: got %b want %b", n, obsIoWe, op == OP_SW); else passCount++;
                checkCount++; if (obsHeld !== 1'b1) $display("FAIL rnd%0d_io_held: got %b want 1", n, obsHeld); else passCount++;
            end
        end
    endtask

    initial begin
        passCount = 0;
        checkCount = 0;
        refLoad = '0;
        refBusErr = 1'b0;
        init_ref_mem();
        test_reset();
        test_dmem_store();
        test_dmem_load();
        test_mmio_store();
        test_mmio_load();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
